pipeline_hazard_ctrl: RTL and testbench

//  Parametrised successor of the Aquila pipeline controller. Generates per-stage

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//  Per-stage flush/stall generation for an NSTAGES-deep in-order pipeline.
//  Handles system-jump redirects, memory-stage freezes, branch/fence.i flushes,
//  a multi-cycle load-use stall counter and a fence.i request/done handshake
//  with the cache subsystem. Outputs are combinational from inputs and state.
//  Optional feature macro: PIPE_BPU_EN (suppress flush on correctly predicted
//  taken branches; mispredictions always flush).
module pipeline_hazard_ctrl #(
   parameter int NSTAGES  = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               unsupported_instr_i,
   input  logic               load_hazard_i,
   input  logic               branch_hit_i,
   input  logic               branch_taken_i,
   input  logic               branch_misprediction_i,
   input  logic               is_fencei_i,
   input  logic               sys_jump_i,
   input  logic               mem_busy_i,
   input  logic               fencei_done_i,
   output logic               fencei_req_o,
   output logic [NSTAGES-1:0] flush_o,
   output logic [NSTAGES-1:0] stall_o,
   output logic               data_hazard_o
);

   localparam int CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LD_STALL = 2'd1,
      ST_FENCE    = 2'd2
   } state_e;

   state_e             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               branch_flush_s;
   logic               ld_start_s;
   logic               ld_hold_s;
   logic [NSTAGES-1:0] flush_s;
   logic [NSTAGES-1:0] stall_s;
   logic               req_s;
   logic               dh_s;

`ifdef PIPE_BPU_EN
   // A taken branch the BPU already followed needs no flush; a wrong guess always does.
   assign branch_flush_s = (branch_taken_i & ~branch_hit_i) | branch_misprediction_i;
`else
   logic unused_bpu_s;
   assign unused_bpu_s   = branch_hit_i ^ branch_misprediction_i;
   assign branch_flush_s = branch_taken_i;
`endif

   // A new load-use stall starts only in IDLE when no higher-priority redirect is present.
   assign ld_start_s = load_hazard_i & ~branch_flush_s & ~is_fencei_i;
   // An ongoing load stall continues unless a branch flush aborts it.
   assign ld_hold_s  = ~branch_flush_s;

   // Combinational flush/stall/request generation in priority order.
   always_comb begin
      flush_s = {NSTAGES{1'b0}};
      stall_s = {NSTAGES{1'b0}};
      req_s   = 1'b0;
      dh_s    = 1'b0;
      if (!rst_ni) begin
         flush_s = {NSTAGES{1'b1}};
      end else if (sys_jump_i) begin
         flush_s = {NSTAGES{1'b1}};
      end else if (mem_busy_i) begin
         // Freeze everything upstream of writeback and push a bubble into writeback.
         stall_s[NSTAGES-2:0] = {(NSTAGES-1){1'b1}};
         flush_s[NSTAGES-2]   = 1'b1;
         req_s                = (state_r == ST_FENCE);
      end else begin
         case (state_r)
            ST_IDLE: begin
               flush_s[0] = branch_flush_s | is_fencei_i;
               flush_s[1] = branch_flush_s | is_fencei_i | unsupported_instr_i | ld_start_s;
               flush_s[2] = is_fencei_i;
               stall_s[0] = ld_start_s;
               dh_s       = ld_start_s;
            end
            ST_LD_STALL: begin
               flush_s[0] = branch_flush_s;
               flush_s[1] = 1'b1;
               stall_s[0] = ld_hold_s;
               dh_s       = ld_hold_s;
            end
            ST_FENCE: begin
               req_s        = 1'b1;
               stall_s[1:0] = 2'b11;
               flush_s[2]   = 1'b1;
            end
            default: begin
               flush_s = {NSTAGES{1'b1}};
            end
         endcase
      end
   end

   assign flush_o       = flush_s;
   assign stall_o       = stall_s;
   assign fencei_req_o  = req_s;
   assign data_hazard_o = dh_s;

   // Controller state and load-stall counter, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else if (sys_jump_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else if (mem_busy_i) begin
         state_r <= state_r;
         cnt_r   <= cnt_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (is_fencei_i) begin
                  state_r <= ST_FENCE;
                  cnt_r   <= CNT_ZERO;
               end else if (ld_start_s && (LOAD_LAT > 1)) begin
                  state_r <= ST_LD_STALL;
                  cnt_r   <= CNT_INIT;
               end else begin
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
               end
            end
            ST_LD_STALL: begin
               if (branch_flush_s || (cnt_r <= CNT_ONE)) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  state_r <= ST_LD_STALL;
                  cnt_r   <= cnt_r - CNT_ONE;
               end
            end
            ST_FENCE: begin
               if (fencei_done_i) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_FENCE;
               end
               cnt_r <= CNT_ZERO;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//  Directed scenarios followed by random traffic, each cycle compared against a
//  behavioural model that tracks "load stall cycles left" and "fence pending".
module tb_pipeline_hazard_ctrl;

   localparam int NSTAGES  = 5;
   localparam int LOAD_LAT = 3;

   // Stimulus masks for one cycle of inputs (RST means reset asserted).
   localparam logic [9:0] NONE = 10'h000;
   localparam logic [9:0] RST  = 10'h200;
   localparam logic [9:0] SJ   = 10'h100;
   localparam logic [9:0] BUSY = 10'h080;
   localparam logic [9:0] FEN  = 10'h040;
   localparam logic [9:0] DONE = 10'h020;
   localparam logic [9:0] LD   = 10'h010;
   localparam logic [9:0] UNS  = 10'h008;
   localparam logic [9:0] BT   = 10'h004;
   localparam logic [9:0] BH   = 10'h002;
   localparam logic [9:0] BM   = 10'h001;

   logic clk = 1'b0;
   logic rst_n, unsup, ld, bhit, btaken, bmis, fencei, sysj, busy, done;
   logic [NSTAGES-1:0] flush, stall;
   logic req, dh;

   int ld_left    = 0;
   bit fence_wait = 1'b0;
   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.NSTAGES(NSTAGES), .LOAD_LAT(LOAD_LAT)) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .unsupported_instr_i    (unsup),
      .load_hazard_i          (ld),
      .branch_hit_i           (bhit),
      .branch_taken_i         (btaken),
      .branch_misprediction_i (bmis),
      .is_fencei_i            (fencei),
      .sys_jump_i             (sysj),
      .mem_busy_i             (busy),
      .fencei_done_i          (done),
      .fencei_req_o           (req),
      .flush_o                (flush),
      .stall_o                (stall),
      .data_hazard_o          (dh)
   );

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, compare outputs with the model, advance the model.
   task automatic cyc(input string tag, input logic [9:0] v);
      logic [4:0] ef, es;
      logic er, ed;
      bit bf, loading;
      @(negedge clk);
      rst_n = ~v[9]; sysj = v[8]; busy = v[7]; fencei = v[6]; done = v[5];
      ld = v[4]; unsup = v[3]; btaken = v[2]; bhit = v[1]; bmis = v[0];
      #1;
`ifdef PIPE_BPU_EN
      bf = (btaken && !bhit) || bmis;
`else
      bf = btaken;
`endif
      ef = 5'd0; es = 5'd0; er = 1'b0; ed = 1'b0; loading = 1'b0;
      if (!rst_n || sysj) begin
         ef = 5'b11111;
      end else if (busy) begin
         es = 5'b01111; ef = 5'b01000; er = fence_wait;
      end else if (fence_wait) begin
         er = 1'b1; es = 5'b00011; ef = 5'b00100;
      end else if (ld_left > 0) begin
         loading = !bf;
         ef[0] = bf; ef[1] = 1'b1; es[0] = loading; ed = loading;
      end else begin
         loading = ld && !bf && !fencei;
         ef[0] = bf || fencei;
         ef[1] = bf || fencei || unsup || loading;
         ef[2] = fencei;
         es[0] = loading; ed = loading;
      end
      check(tag, {flush, stall, req, dh}, {ef, es, er, ed});
      if (!rst_n || sysj) begin
         ld_left = 0; fence_wait = 1'b0;
      end else if (busy) begin
         ld_left = ld_left;
      end else if (fence_wait) begin
         if (done) fence_wait = 1'b0;
      end else if (ld_left > 0) begin
         ld_left = bf ? 0 : ld_left - 1;
      end else if (fencei) begin
         fence_wait = 1'b1;
      end else if (ld && !bf) begin
         ld_left = LOAD_LAT - 1;
      end
   endtask

   initial begin
      logic [9:0] v;
      rst_n = 1'b0; unsup = 1'b0; ld = 1'b0; bhit = 1'b0; btaken = 1'b0; bmis = 1'b0;
      fencei = 1'b0; sysj = 1'b0; busy = 1'b0; done = 1'b0;

      // Reset held three cycles, then quiet pipeline.
      for (int i = 0; i < 3; i++) cyc("reset", RST);
      check("reset_flush_const", {7'd0, flush}, {7'd0, 5'b11111});
      cyc("idle", NONE);
      check("idle_flush_const", {7'd0, flush}, 12'd0);

      // Load-use hazard pulse stalls exactly LOAD_LAT cycles.
      cyc("ld_detect", LD);
      cyc("ld_stall1", NONE);
      cyc("ld_stall2", NONE);
      check("ld_stall2_const", {stall, flush, dh, 1'b0}, {5'b00001, 5'b00010, 1'b1, 1'b0});
      cyc("ld_done", NONE);

      // fence.i handshake, done at cycle 6.
      cyc("fence_c1", FEN);
      check("fence_c1_const", {7'd0, flush}, {7'd0, 5'b00111});
      for (int i = 2; i <= 5; i++) cyc("fence_wait", NONE);
      cyc("fence_c6_done", DONE);
      cyc("fence_c7", NONE);
      check("fence_c7_req", {11'd0, req}, 12'd0);

      // Memory busy freezes an ongoing load stall with two cycles remaining.
      cyc("lb_detect", LD);
      for (int i = 0; i < 4; i++) cyc("lb_busy", BUSY);
      cyc("lb_stall1", NONE);
      cyc("lb_stall2", NONE);
      cyc("lb_done", NONE);

      // sys_jump during FENCE; later done is ignored.
      cyc("sj_fence", FEN);
      cyc("sj_wait", NONE);
      cyc("sj_jump", SJ);
      cyc("sj_after", NONE);
      cyc("sj_late_done", DONE);
      cyc("sj_idle", NONE);

      // Branch variants, unsupported instruction, branch aborting a load stall.
      cyc("br_hit_taken", BT | BH);
      cyc("br_taken", BT);
      cyc("br_mispredict", BT | BH | BM);
      cyc("unsupported", UNS);
      cyc("ab_detect", LD);
      cyc("ab_branch", BT);
      cyc("ab_after", LD);
      cyc("ab_stall", NONE);
      cyc("fence_busy_c1", FEN);
      cyc("fence_busy_done", BUSY | DONE);
      cyc("fence_busy_c3", NONE);
      cyc("fence_busy_done2", DONE);
      cyc("fence_busy_c5", NONE);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         v = NONE;
         if ($urandom_range(0, 49) == 0) v |= RST;
         if ($urandom_range(0, 29) == 0) v |= SJ;
         if ($urandom_range(0, 5) == 0)  v |= BUSY;
         if ($urandom_range(0, 11) == 0) v |= FEN;
         if ($urandom_range(0, 3) == 0)  v |= DONE;
         if ($urandom_range(0, 3) == 0)  v |= LD;
         if ($urandom_range(0, 5) == 0)  v |= UNS;
         if ($urandom_range(0, 5) == 0)  v |= BT;
         if ($urandom_range(0, 2) == 0)  v |= BH;
         if ($urandom_range(0, 7) == 0)  v |= BM;
         cyc("random", v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
